// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, the digit width and the significant-digit count.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned MAX_DIGITS  = 20;
  localparam int unsigned MAX_BCD_W   = BCD_DIGIT_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 1 + index of the highest non-zero digit among the lowest 'digits' digits; 1 for zero
  function automatic int unsigned ndig_calc(input logic [MAX_BCD_W-1:0] bcd,
                                            input int unsigned          digits);
    int unsigned n;
    n = 1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < digits) && (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0)) begin
        n = i + 1;
      end
    end
    return n;
  endfunction

  // True when 10**digits exceeds the largest magnitude the input can carry
  function automatic bit digits_fit(input int unsigned bin_w,
                                    input int unsigned digits,
                                    input bit          is_signed);
    logic [127:0] p10;
    logic [127:0] mag;
    p10 = 128'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p10 = p10 * 128'd10;
    end
    if (is_signed) begin
      mag = 128'd1 << (bin_w - 1);
    end else begin
      mag = (128'd1 << bin_w) - 128'd1;
    end
    return p10 > mag;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= BCD_DIGIT_W'(5)) begin
      adj_c = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready on both sides, optional two's-complement input and digit count.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_W-1:0]                  in_bin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]     out_bcd,
  output logic                              out_neg,
  output logic [$clog2(DIGITS+1)-1:0]       out_ndig,
  output logic                              busy
);

  localparam int unsigned BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned NDIG_W    = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W     = $clog2(BIN_W + 1);
  localparam bit          IS_SIGNED = (SIGNED != 0);

  // Elaboration-time parameter sanity
  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be 2 or more");
  end
  if (DIGITS > MAX_DIGITS) begin : g_bad_digits_max
    $error("bin_to_bcd_seq: DIGITS exceeds MAX_DIGITS of bcd_pkg");
  end
  if (!digits_fit(BIN_W, DIGITS, IS_SIGNED)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for the largest input magnitude");
  end

  state_e              state;
  state_e              state_nxt;
  logic [BIN_W-1:0]    shift_reg;
  logic [BIN_W-1:0]    shift_nxt;
  logic [BIN_W-1:0]    shift_sh;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_nxt;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_sh;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                neg;
  logic                neg_nxt;
  logic                in_neg_c;
  logic [BIN_W-1:0]    in_mag_c;
  logic                out_valid_nxt;
  logic [BCD_W-1:0]    out_bcd_nxt;
  logic                out_neg_nxt;
  logic [NDIG_W-1:0]   out_ndig_nxt;
  logic                busy_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj_c (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign {bcd_sh, shift_sh} = {bcd_adj, shift_reg} << 1;

  // Magnitude of a negative input is taken modulo 2**BIN_W so the most negative value is exact
  assign in_neg_c = IS_SIGNED && in_bin[BIN_W-1];
  assign in_mag_c = in_neg_c ? (~in_bin + BIN_W'(1)) : in_bin;

  assign in_ready = (state == IDLE) && !rst;

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    bcd_nxt       = bcd;
    cnt_nxt       = cnt;
    neg_nxt       = neg;
    out_valid_nxt = out_valid;
    out_bcd_nxt   = out_bcd;
    out_neg_nxt   = out_neg;
    out_ndig_nxt  = out_ndig;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_nxt = in_mag_c;
          neg_nxt   = in_neg_c;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(BIN_W)) begin
          out_bcd_nxt   = bcd;
          out_neg_nxt   = neg;
          out_ndig_nxt  = NDIG_W'(ndig_calc(MAX_BCD_W'(bcd), DIGITS));
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          bcd_nxt   = bcd_sh;
          shift_nxt = shift_sh;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SHIFT);
  end

  // State and register bank; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ndig  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bcd       <= bcd_nxt;
      cnt       <= cnt_nxt;
      neg       <= neg_nxt;
      out_valid <= out_valid_nxt;
      out_bcd   <= out_bcd_nxt;
      out_neg   <= out_neg_nxt;
      out_ndig  <= out_ndig_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
